// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
// Shared definitions for the DDS modulator path: mode codes (also used by the
// DDS wrapper), symbol-source FSM state codes, LFSR width, and the LFSR step /
// symbol mapping helpers.
// -----------------------------------------------------------------------------
package mod_pkg;

    localparam int unsigned LFSR_W = 5;

    // DDS mode codes
    localparam logic [2:0] MODE_SINE   = 3'b000;
    localparam logic [2:0] MODE_COSINE = 3'b001;
    localparam logic [2:0] MODE_SQUARE = 3'b010;
    localparam logic [2:0] MODE_SAW    = 3'b011;
    localparam logic [2:0] MODE_ASK    = 3'b100;
    localparam logic [2:0] MODE_BPSK   = 3'b101;
    localparam logic [2:0] MODE_FSK    = 3'b110;
    localparam logic [2:0] MODE_QPSK   = 3'b111;

    // Symbol-source FSM states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // One Fibonacci step of x^5 + x^3 + 1; never reaches the all-zero state.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[0] ^ s[2], s[LFSR_W-1:1]};
    endfunction

    // QPSK carries two bits per symbol, every other mode one bit.
    function automatic logic [1:0] sym_map(input logic [LFSR_W-1:0] s, input logic [2:0] m);
        return (m == MODE_QPSK) ? {s[0], s[1]} : {1'b0, s[0]};
    endfunction

endpackage

// File: rtl/mod_lfsr5.sv
// -----------------------------------------------------------------------------
// mod_lfsr5
// 5-bit maximal-length LFSR with seed load and a 1- or 2-step advance.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset (loads SEED)
//   load_i   restart from SEED (combined with adv_i, the advance starts at SEED)
//   adv_i    advance this cycle
//   two_i    advance two steps instead of one
//   state_o  current LFSR state
// -----------------------------------------------------------------------------
module mod_lfsr5
    import mod_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 5'b00001
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic              two_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] base;
    logic [LFSR_W-1:0] one_step;

    always_comb begin
        base     = load_i ? SEED : lfsr_q;
        one_step = lfsr_step(base);
        lfsr_d   = base;
        if (adv_i) begin
            lfsr_d = two_i ? lfsr_step(one_step) : one_step;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/mod_symbol_source.sv
// -----------------------------------------------------------------------------
// mod_symbol_source
// Upstream stage of the DDS modulator: emits LFSR-derived symbols, one per
// symbol period, with a mode that is latched only at symbol boundaries.
// Continuous (until stop) or fixed-length burst transmission.
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   en_i           advance enable; low freezes counter, FSM and outputs
//   start_i        begin transmission (IDLE only)
//   stop_i         abort to IDLE (highest priority)
//   continuous_i   1 = run until stop, 0 = burst of burst_len_i symbols
//   burst_len_i    symbols per burst; 0 blocks a burst start
//   mode_i         requested DDS mode
//   data_o         current symbol
//   mode_o         boundary-latched mode
//   sym_stb_o      one-cycle pulse when a new symbol first appears
//   busy_o         high while running
// -----------------------------------------------------------------------------
module mod_symbol_source
    import mod_pkg::*;
#(
    parameter int unsigned       FREQ_CLK  = 50_000_000,
    parameter int unsigned       FREQ_SYM  = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 5'b00001
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       continuous_i,
    input  logic [7:0] burst_len_i,
    input  logic [2:0] mode_i,
    output logic [1:0] data_o,
    output logic [2:0] mode_o,
    output logic       sym_stb_o,
    output logic       busy_o
);

    localparam int unsigned SYM_CYCLES = FREQ_CLK / FREQ_SYM;
    localparam int unsigned CNT_W      = $clog2(SYM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);

    logic             state_q, state_d;
    logic [1:0]       data_q, data_d;
    logic [2:0]       mode_q, mode_d;
    logic             stb_q, stb_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rem_q, rem_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic              qpsk;
    logic [LFSR_W-1:0] lfsr_state;

    assign qpsk = (mode_i == MODE_QPSK);

    mod_lfsr5 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .two_i   (qpsk),
        .state_o (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mode_d    = mode_q;
        stb_d     = 1'b0;
        count_d   = count_q;
        rem_d     = rem_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        if (stop_i) begin
            state_d = ST_IDLE;
            data_d  = 2'b00;
            count_d = '0;
        end else if (en_i) begin
            if (state_q == ST_IDLE) begin
                if (start_i && (continuous_i || (burst_len_i != 8'd0))) begin
                    state_d   = ST_RUN;
                    data_d    = sym_map(LFSR_SEED, mode_i);
                    mode_d    = mode_i;
                    stb_d     = 1'b1;
                    count_d   = '0;
                    rem_d     = burst_len_i - 8'd1;
                    lfsr_load = 1'b1;
                    lfsr_adv  = 1'b1;
                end
            end else if (count_q == CNT_LAST) begin
                if (continuous_i || (rem_q != 8'd0)) begin
                    data_d   = sym_map(lfsr_state, mode_i);
                    mode_d   = mode_i;
                    stb_d    = 1'b1;
                    count_d  = '0;
                    lfsr_adv = 1'b1;
                    if (!continuous_i) begin
                        rem_d = rem_q - 8'd1;
                    end
                end else begin
                    // Burst exhausted; mode_o keeps the last symbol's mode.
                    state_d = ST_IDLE;
                    data_d  = 2'b00;
                    count_d = '0;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= 2'b00;
            mode_q  <= 3'b000;
            stb_q   <= 1'b0;
            count_q <= '0;
            rem_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            stb_q   <= stb_d;
            count_q <= count_d;
            rem_q   <= rem_d;
        end
    end

    assign data_o    = data_q;
    assign mode_o    = mode_q;
    assign sym_stb_o = stb_q;
    assign busy_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_mod_symbol_source.sv
// -----------------------------------------------------------------------------
// tb_mod_symbol_source
// Self-checking bench for mod_symbol_source with SYM_CYCLES = 8. A reference
// model walks a precomputed LFSR sequence by index and is compared against the
// DUT after every clock edge; directed tables and sequences add fixed values.
// -----------------------------------------------------------------------------
module tb_mod_symbol_source;

    localparam int SYM = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] blen;
    logic [2:0] mode_in;
    logic [1:0] data_o;
    logic [2:0] mode_o;
    logic       stb_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    mod_symbol_source #(
        .FREQ_CLK  (8),
        .FREQ_SYM  (1),
        .LFSR_SEED (5'b00001)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .start_i      (start),
        .stop_i       (stop),
        .continuous_i (cont),
        .burst_len_i  (blen),
        .mode_i       (mode_in),
        .data_o       (data_o),
        .mode_o       (mode_o),
        .sym_stb_o    (stb_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [4:0] seq [31];
    bit         m_busy;
    int         m_cnt;
    logic [7:0] m_left;
    int         m_pos;
    logic [1:0] m_data;
    logic [2:0] m_mode;
    bit         m_stb;

    task automatic build_seq();
        logic [4:0] s;
        s = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            seq[i] = s;
            s = {s[0] ^ s[2], s[4:1]};
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_left = 8'd0; m_pos = 0;
        m_data = 2'b00; m_mode = 3'b000; m_stb = 0;
    endtask

    task automatic m_emit(input logic [2:0] md);
        logic [4:0] s;
        s = seq[m_pos];
        if (md == 3'b111) begin
            m_data = {s[0], s[1]};
            m_pos  = (m_pos + 2) % 31;
        end else begin
            m_data = {1'b0, s[0]};
            m_pos  = (m_pos + 1) % 31;
        end
        m_mode = md;
        m_stb  = 1;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        m_stb = 0;
        if (stop) begin
            m_busy = 0; m_data = 2'b00; m_cnt = 0;
        end else if (en) begin
            if (!m_busy) begin
                if (start && (cont || blen != 8'd0)) begin
                    m_pos = 0;
                    m_emit(mode_in);
                    m_left = blen - 8'd1;
                    m_busy = 1;
                end
            end else if (m_cnt == SYM - 1) begin
                if (cont || m_left != 8'd0) begin
                    if (!cont) m_left = m_left - 8'd1;
                    m_emit(mode_in);
                end else begin
                    m_busy = 0; m_data = 2'b00; m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_data", 8'(data_o), 8'(m_data));
        chk("model_mode", 8'(mode_o), 8'(m_mode));
        chk("model_stb",  8'(stb_o),  8'(m_stb));
        chk("model_busy", 8'(busy_o), 8'(m_busy));
    endtask

    typedef struct {
        logic [2:0] mode;
        logic       cont;
        logic [7:0] blen;
        int         nsym;
        logic [7:0] syms;  // symbol s at bits [2s+1:2s]
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [7:0] sh;
        logic [1:0] held;

        build_seq();
        vecs[0] = '{3'b101, 1'b0, 8'd4, 4, 8'b00_00_00_01};  // BPSK burst
        vecs[1] = '{3'b111, 1'b1, 8'd1, 3, 8'b00_01_00_10};  // QPSK continuous
        vecs[2] = '{3'b000, 1'b0, 8'd2, 2, 8'b00_00_00_01};  // SINE burst
        vecs[3] = '{3'b111, 1'b0, 8'd2, 2, 8'b00_00_00_10};  // QPSK burst

        en = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        blen = 8'd0; mode_in = 3'b110;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_data", 8'(data_o), 8'd0);
        chk("rst_mode", 8'(mode_o), 8'd0);
        chk("rst_stb",  8'(stb_o),  8'd0);
        chk("rst_busy", 8'(busy_o), 8'd0);
        #1 rst = 1'b0;
        tick();

        // ---------------- table-driven transactions ----------------
        for (int r = 0; r < 4; r++) begin
            mode_in = vecs[r].mode;
            cont    = vecs[r].cont;
            blen    = vecs[r].blen;
            start   = 1'b1;
            for (int s = 0; s < vecs[r].nsym; s++) begin
                tick();
                start = 1'b0;
                sh   = vecs[r].syms >> (2 * s);
                held = sh[1:0];
                chk("vec_stb",  8'(stb_o),  8'd1);
                chk("vec_data", 8'(data_o), 8'(held));
                chk("vec_mode", 8'(mode_o), 8'(vecs[r].mode));
                for (int k = 1; k < SYM; k++) begin
                    tick();
                    chk("vec_hold", 8'(data_o), 8'(held));
                    chk("vec_nostb", 8'(stb_o), 8'd0);
                end
            end
            if (vecs[r].cont) stop = 1'b1;
            tick();
            stop = 1'b0;
            chk("vec_end_busy", 8'(busy_o), 8'd0);
            chk("vec_end_data", 8'(data_o), 8'd0);
            chk("vec_end_stb",  8'(stb_o),  8'd0);
            tick();
            tick();
        end

        // ---------------- reset mid-RUN ----------------
        mode_in = 3'b101; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_data", 8'(data_o), 8'd0);
        chk("arst_mode", 8'(mode_o), 8'd0);
        chk("arst_busy", 8'(busy_o), 8'd0);
        chk("arst_stb",  8'(stb_o),  8'd0);
        #1 rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_seed_data", 8'(data_o), 8'b01);
        chk("restart_stb", 8'(stb_o), 8'd1);

        // ---------------- mode change mid-symbol ----------------
        stop = 1'b1; tick(); stop = 1'b0; tick();
        mode_in = 3'b101; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        mode_in = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midsym_mode", 8'(mode_o), 8'b101);
            chk("midsym_data", 8'(data_o), 8'b01);
        end
        tick();
        chk("bound_mode", 8'(mode_o), 8'b111);
        chk("bound_stb",  8'(stb_o),  8'd1);
        chk("bound_data", 8'(data_o), 8'b00);

        // ---------------- en freeze ----------------
        stop = 1'b1; tick(); stop = 1'b0; tick();
        mode_in = 3'b101; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("frz_stb",  8'(stb_o),  8'd0);
            chk("frz_data", 8'(data_o), 8'b01);
            chk("frz_mode", 8'(mode_o), 8'b101);
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("resume_nostb", 8'(stb_o), 8'd0);
        end
        tick();
        chk("resume_stb", 8'(stb_o), 8'd1);

        // ---------------- stop at boundary, zero-length burst ----------------
        repeat (7) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopb_busy", 8'(busy_o), 8'd0);
        chk("stopb_data", 8'(data_o), 8'd0);
        chk("stopb_stb",  8'(stb_o),  8'd0);
        cont = 1'b0; blen = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zlen_busy", 8'(busy_o), 8'd0);
        chk("zlen_stb",  8'(stb_o),  8'd0);
        tick();

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            en    = ($urandom % 8) != 0;
            stop  = en && (($urandom % 80) == 0);
            start = ($urandom % 6) == 0;
            if (($urandom % 40) == 0) cont = $urandom % 2;
            if (start) blen = 8'($urandom_range(0, 4));
            if (($urandom % 10) == 0) mode_in = 3'($urandom % 8);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
